// File: rtl/wam_pkg.sv
// Shared types and helpers for the Whac-A-Mole sequencer.
package wam_pkg;
  typedef enum logic [1:0] {IDLE, GAP, UP, OVER} state_t;

  localparam int NHOLES = 4;
  localparam int BCD_W  = 8;

  // Two-digit BCD decrement; ones digit 0 borrows from tens.
  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] t);
    if (t[3:0] == 4'd0) bcd_dec = {t[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {t[7:4], t[3:0] - 4'd1};
  endfunction
endpackage

// File: rtl/wam_ctl_if.sv
// Board-side and score-side signals of the mole sequencer.
interface wam_ctl_if;
  import wam_pkg::*;
  logic              tick;
  logic              start;
  logic [NHOLES-1:0] sw;
  logic [NHOLES-1:0] mole;
  logic              hit_pulse;
  logic              miss_pulse;
  logic              score_clr;
  logic [BCD_W-1:0]  time_left;
  logic              busy;
  logic              over;

  modport master (output tick, start, sw,
                  input  mole, hit_pulse, miss_pulse, score_clr, time_left, busy, over);
  modport slave  (input  tick, start, sw,
                  output mole, hit_pulse, miss_pulse, score_clr, time_left, busy, over);
endinterface

// File: rtl/wam_lfsr.sv
// 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1, free-running; exposes its low bits.
module wam_lfsr #(
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int          OUT_W = 2
) (
  input  logic             clk,
  input  logic             clr,
  output logic [OUT_W-1:0] q
);
  logic [7:0] r;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r <= SEED;
    else     r <= {1'b0, r[7:1]} ^ (r[0] ? 8'hB8 : 8'h00);
  end

  assign q = r[OUT_W-1:0];
endmodule

// File: rtl/wam_ctl.sv
// Whac-A-Mole game sequencer: mole pick/timing, hit detection, game countdown.
module wam_ctl
  import wam_pkg::*;
#(
  parameter int          SEC_TICKS  = 1000,
  parameter logic [7:0]  GAME_SECS  = 8'h30,
  parameter int          MOLE_TICKS = 800,
  parameter int          GAP_TICKS  = 300,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic      clk,
  input logic      clr,
  wam_ctl_if.slave bus
);
  localparam int CW = 16;

  state_t            state;
  logic [1:0]        raw, pick, prev;
  logic [NHOLES-1:0] s1, s2, s3, rise;
  logic [CW-1:0]     sec_cnt, gap_cnt, up_cnt;
  logic [BCD_W-1:0]  t_next;
  logic              sec_wrap, game_end, hit, wrong, active;

  wam_lfsr #(.SEED(LFSR_SEED), .OUT_W(2)) u_lfsr (.clk(clk), .clr(clr), .q(raw));

  // Never show the same hole twice in a row.
  assign pick     = (raw == prev) ? raw + 2'd1 : raw;
  assign rise     = s2 & ~s3;
  assign hit      = |(rise & bus.mole);
  assign wrong    = |(rise & ~bus.mole);
  assign active   = (state == GAP) || (state == UP);
  assign sec_wrap = bus.tick && (sec_cnt == CW'(SEC_TICKS - 1));
  assign t_next   = bcd_dec(bus.time_left);
  assign game_end = sec_wrap && (t_next == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state          <= IDLE;
      prev           <= '0;
      s1             <= '0;
      s2             <= '0;
      s3             <= '0;
      sec_cnt        <= '0;
      gap_cnt        <= '0;
      up_cnt         <= '0;
      bus.mole       <= '0;
      bus.hit_pulse  <= 1'b0;
      bus.miss_pulse <= 1'b0;
      bus.score_clr  <= 1'b0;
      bus.time_left  <= '0;
      bus.busy       <= 1'b0;
      bus.over       <= 1'b0;
    end else begin
      s1             <= bus.sw;
      s2             <= s1;
      s3             <= s2;
      bus.hit_pulse  <= 1'b0;
      bus.miss_pulse <= 1'b0;
      bus.score_clr  <= 1'b0;

      case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            state         <= GAP;
            bus.time_left <= GAME_SECS;
            sec_cnt       <= '0;
            gap_cnt       <= CW'(GAP_TICKS);
            bus.score_clr <= 1'b1;
            bus.busy      <= 1'b1;
            bus.over      <= 1'b0;
            bus.mole      <= '0;
          end
        end
        GAP: begin
          if (bus.tick) begin
            if (gap_cnt <= CW'(1)) begin
              state    <= UP;
              bus.mole <= {{(NHOLES-1){1'b0}}, 1'b1} << pick;
              up_cnt   <= CW'(MOLE_TICKS);
              prev     <= pick;
            end else begin
              gap_cnt <= gap_cnt - CW'(1);
            end
          end
        end
        UP: begin
          if (bus.tick) up_cnt <= up_cnt - CW'(1);
          // Correct hit beats timeout, timeout beats wrong-hole presses.
          if (hit) begin
            bus.hit_pulse <= 1'b1;
            bus.mole      <= '0;
            gap_cnt       <= CW'(GAP_TICKS);
            state         <= GAP;
          end else if (bus.tick && up_cnt <= CW'(1)) begin
            bus.miss_pulse <= 1'b1;
            bus.mole       <= '0;
            gap_cnt        <= CW'(GAP_TICKS);
            state          <= GAP;
          end else if (wrong) begin
            bus.miss_pulse <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Game clock overrides the hole FSM when the countdown hits 00.
      if (active && bus.tick) begin
        if (sec_wrap) begin
          sec_cnt       <= '0;
          bus.time_left <= t_next;
        end else begin
          sec_cnt <= sec_cnt + CW'(1);
        end
        if (game_end) begin
          state    <= OVER;
          bus.mole <= '0;
          bus.busy <= 1'b0;
          bus.over <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wam_ctl.sv
// Directed bench for wam_ctl with a short game (4 ticks/s, 3 s, tick every 2 clk).
module tb_wam_ctl;
  logic clk, clr, tick_en;
  int   n_chk, n_err, tcount;

  wam_ctl_if bus();

  wam_ctl #(
    .SEC_TICKS(4), .GAME_SECS(8'h03), .MOLE_TICKS(5), .GAP_TICKS(2), .LFSR_SEED(8'hA5)
  ) dut (.clk(clk), .clr(clr), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; tick alternates so every second edge carries a tick.
  task automatic clk1();
    logic t;
    t = bus.tick;
    @(posedge clk); #1;
    if (t) tcount++;
    bus.tick = tick_en & ~bus.tick;
  endtask

  task automatic wait_mole(input string tag);
    int n;
    n = 0;
    while (bus.mole == '0 && n < 40) begin clk1(); n++; end
    chk(tag, bus.mole != '0, 1);
  endtask

  // Reset, start a game, return on the edge the first mole appears.
  task automatic new_game();
    clr = 1'b1; tick_en = 1'b0; bus.tick = 1'b0; bus.sw = '0; bus.start = 1'b0;
    clk1(); clk1();
    clr = 1'b0; clk1();
    bus.start = 1'b1; clk1();
    bus.start = 1'b0;
    tcount = 0; tick_en = 1'b1; bus.tick = 1'b1;
    wait_mole("ng_mole_up");
  endtask

  initial begin
    logic [3:0] m, prevm, lastm;
    int tc0, n, rep, mcount;
    logic seen4, seen8, pulses;
    n_chk = 0; n_err = 0; tcount = 0;
    clr = 1'b1; tick_en = 1'b0;
    bus.tick = 1'b0; bus.start = 1'b0; bus.sw = '0;
    clk1(); clk1();
    chk("rst_mole", bus.mole, 0);
    chk("rst_time", bus.time_left, 0);
    chk("rst_flags", {bus.busy, bus.over, bus.hit_pulse, bus.miss_pulse, bus.score_clr}, 0);
    clr = 1'b0; clk1();

    // Game start and first mole.
    bus.start = 1'b1; clk1();
    chk("t1_score_clr", bus.score_clr, 1);
    chk("t1_time", bus.time_left, 8'h03);
    chk("t1_busy", bus.busy, 1);
    chk("t1_mole0", bus.mole, 0);
    bus.start = 1'b0; clk1();
    chk("t1_score_clr_off", bus.score_clr, 0);
    tcount = 0; tick_en = 1'b1; bus.tick = 1'b1;
    wait_mole("t1_mole_up");
    chk("t1_gap_ticks", tcount, 2);
    chk("t1_onehot", $countones(bus.mole), 1);
    chk("t1_busy_up", bus.busy, 1);

    // Correct hit: pulse on the third edge after the press, one clk wide.
    m = bus.mole; bus.sw = m;
    clk1(); chk("t2_hit_e1", bus.hit_pulse, 0);
    clk1(); chk("t2_hit_e2", bus.hit_pulse, 0);
    clk1(); chk("t2_hit_e3", bus.hit_pulse, 1);
    chk("t2_mole_clr", bus.mole, 0);
    chk("t2_no_miss", bus.miss_pulse, 0);
    tc0 = tcount;
    clk1(); chk("t2_hit_one", bus.hit_pulse, 0);
    bus.sw = '0;
    wait_mole("t2_mole_up");
    chk("t2_gap_ticks", tcount - tc0, 2);
    chk("t2_diff_hole", bus.mole == m, 0);
    chk("t2_onehot", $countones(bus.mole), 1);

    // Timeout after 5 ticks.
    new_game();
    tc0 = tcount; n = 0;
    while (!bus.miss_pulse && n < 40) begin clk1(); n++; end
    chk("t3_timeout_miss", bus.miss_pulse, 1);
    chk("t3_up_ticks", tcount - tc0, 5);
    chk("t3_mole_clr", bus.mole, 0);
    chk("t3_no_hit", bus.hit_pulse, 0);
    clk1(); chk("t3_miss_one", bus.miss_pulse, 0);

    // Single wrong hole.
    new_game();
    m = bus.mole; bus.sw = {m[2:0], m[3]};
    clk1(); clk1(); clk1();
    chk("t3_wrong_miss", bus.miss_pulse, 1);
    chk("t3_wrong_mole", bus.mole, m);
    chk("t3_wrong_nohit", bus.hit_pulse, 0);
    clk1(); chk("t3_wrong_one", bus.miss_pulse, 0);

    // Three wrong holes at once still give one pulse.
    new_game();
    m = bus.mole; bus.sw = ~m;
    clk1(); clk1(); clk1();
    chk("t3_multi_miss", bus.miss_pulse, 1);
    chk("t3_multi_mole", bus.mole, m);
    clk1(); chk("t3_multi_one", bus.miss_pulse, 0);

    // Hit arriving on the same edge as the up timeout.
    new_game();
    m = bus.mole;
    repeat (7) clk1();
    bus.sw = m;
    clk1(); clk1(); clk1();
    chk("t4_hit", bus.hit_pulse, 1);
    chk("t4_no_miss", bus.miss_pulse, 0);
    chk("t4_mole_clr", bus.mole, 0);
    clk1(); chk("t4_no_late_miss", bus.miss_pulse, 0);
    bus.sw = '0;

    // Full countdown to OVER, then restart.
    new_game();
    seen4 = 1'b0; seen8 = 1'b0; n = 0;
    while (!bus.over && n < 100) begin
      clk1(); n++;
      if (tcount == 4 && !seen4) begin seen4 = 1'b1; chk("t5_time_02", bus.time_left, 8'h02); end
      if (tcount == 8 && !seen8) begin seen8 = 1'b1; chk("t5_time_01", bus.time_left, 8'h01); end
    end
    chk("t5_over", bus.over, 1);
    chk("t5_end_ticks", tcount, 12);
    chk("t5_time_00", bus.time_left, 0);
    chk("t5_mole0", bus.mole, 0);
    chk("t5_busy0", bus.busy, 0);
    bus.sw = 4'hF; pulses = 1'b0;
    repeat (6) begin clk1(); pulses = pulses | bus.hit_pulse | bus.miss_pulse | bus.score_clr; end
    chk("t5_over_nopulse", pulses, 0);
    chk("t5_over_hold", {bus.over, bus.time_left}, 9'h100);
    bus.sw = '0;
    bus.start = 1'b1; clk1();
    chk("t5_restart_time", bus.time_left, 8'h03);
    chk("t5_restart_clr", bus.score_clr, 1);
    chk("t5_restart_flags", {bus.busy, bus.over}, 2'b10);
    clk1(); chk("t5_start_ignored", bus.score_clr, 0);
    bus.start = 1'b0;

    // Asynchronous clear mid-UP.
    new_game();
    clr = 1'b1; #1;
    chk("t6_clr_mole", bus.mole, 0);
    chk("t6_clr_time", bus.time_left, 0);
    chk("t6_clr_flags", {bus.busy, bus.over}, 0);
    clk1(); clr = 1'b0;

    // 100 consecutive moles across auto-restarted games never repeat a hole.
    tick_en = 1'b1; bus.start = 1'b1;
    prevm = '0; lastm = '0; rep = 0; mcount = 0; n = 0;
    while (mcount < 100 && n < 5000) begin
      clk1(); n++;
      if (bus.mole != '0 && lastm == '0) begin
        mcount++;
        if (bus.mole == prevm) rep++;
        if ($countones(bus.mole) != 1) rep++;
        prevm = bus.mole;
      end
      lastm = bus.mole;
    end
    chk("t6_mole_count", mcount, 100);
    chk("t6_no_repeat", rep, 0);
    bus.start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
